// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS control unit.
//   - instruction opcode and R-type funct encodings
//   - ALUOp codes passed from the control FSM to the ALU decoder
//   - ALU control encodings driven onto the datapath
//   - control FSM state encodings (12 of the 16 codes used)
package mc_pkg;

  localparam int STATE_W = 4;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control encodings
  localparam logic [2:0] AC_ADD = 3'b010;
  localparam logic [2:0] AC_SUB = 3'b110;
  localparam logic [2:0] AC_AND = 3'b000;
  localparam logic [2:0] AC_OR  = 3'b001;
  localparam logic [2:0] AC_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: combinational ALU decoder.
//   aluop      in  2  ADD / SUB / use funct
//   funct      in  6  instr[5:0]
//   alucontrol out 3  ALU operation select
//   bad_funct  out 1  funct not supported (only meaningful when aluop = FUNCT)
module mc_aludec
  import mc_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol,
  output logic        bad_funct
);

  always_comb begin
    alucontrol = AC_ADD;
    bad_funct  = 1'b0;
    case (aluop)
      ALUOP_SUB: alucontrol = AC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = AC_ADD;
          FN_SUB:  alucontrol = AC_SUB;
          FN_AND:  alucontrol = AC_AND;
          FN_OR:   alucontrol = AC_OR;
          FN_SLT:  alucontrol = AC_SLT;
          // Unsupported funct: keep a harmless add, raise the flag.
          default: bad_funct  = 1'b1;
        endcase
      end
      default: alucontrol = AC_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: control FSM of the multicycle MIPS core.
// Sequences the shared datapath through fetch/decode/execute/writeback for
// lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.
//   clk, reset          clock; asynchronous active-high reset (state -> FETCH)
//   op, funct           instruction fields from IR
//   zero                ALU zero flag of the current cycle (beq)
//   mem_ready           memory completes the access this cycle
//   pcen .. illegal     datapath enables, mux selects, ALU control, illegal flag
//
// Memory handshake: memread (FETCH/MEMRD) or memwrite (MEMWR) is the request
// and is held steady while mem_ready is low; the access completes in the cycle
// where request and mem_ready are both high, and the FSM advances on that edge.
// No other state looks at mem_ready.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       memread,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_t state;
  state_t state_next;
  aluop_t aluop;
  logic   pcwrite;
  logic   branch;
  logic   bad_funct;

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol),
    .bad_funct  (bad_funct)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // ALUOp is kept in its own process so the decoder's bad_funct can feed
  // the main decode below without a combinational loop through one block.
  always_comb begin
    aluop = ALUOP_ADD;
    if (!reset) begin
      case (state)
        S_EXECUTE: aluop = ALUOP_FUNCT;
        S_BRANCH:  aluop = ALUOP_SUB;
        default:   aluop = ALUOP_ADD;
      endcase
    end
  end

  always_comb begin
    state_next = S_FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    memread    = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    illegal    = 1'b0;
    // While reset is high every output sits at its reset value, so a write
    // strobe drops the instant reset rises rather than at the next edge.
    if (!reset) begin
      case (state)
        S_FETCH: begin
          memread    = 1'b1;
          alusrcb    = 2'b01;
          irwrite    = mem_ready;
          pcwrite    = mem_ready;
          state_next = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          case (op)
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_RTYPE:     state_next = S_EXECUTE;
            OP_BEQ:       state_next = S_BRANCH;
            OP_ADDI:      state_next = S_ADDIEX;
            OP_J:         state_next = S_JUMP;
            default: begin
              illegal    = 1'b1;
              state_next = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          // Only lw/sw reach here; anything but lw is treated as a store.
          state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          memread    = 1'b1;
          iord       = 1'b1;
          state_next = mem_ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          memtoreg   = 1'b1;
          regwrite   = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMWR: begin
          iord       = 1'b1;
          memwrite   = 1'b1;
          state_next = mem_ready ? S_FETCH : S_MEMWR;
        end
        S_EXECUTE: begin
          alusrca    = 1'b1;
          illegal    = bad_funct;
          state_next = bad_funct ? S_FETCH : S_ALUWB;
        end
        S_ALUWB: begin
          regdst     = 1'b1;
          regwrite   = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          alusrca    = 1'b1;
          pcsrc      = 2'b01;
          branch     = 1'b1;
          state_next = S_FETCH;
        end
        S_ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          state_next = S_ADDIWB;
        end
        S_ADDIWB: begin
          regwrite   = 1'b1;
          state_next = S_FETCH;
        end
        S_JUMP: begin
          pcsrc      = 2'b10;
          pcwrite    = 1'b1;
          state_next = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

  assign pcen = pcwrite | (branch & zero);

endmodule
